sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arb_pkg.sv | 17 +
 rtl/rr_arb2.sv | 32 +++
 rtl/sram_arbiter.sv | 120 ++++++++++++
 tb/tb_sram_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StSetup   = 2'd1,
        StStrobe  = 2'd2,
        StRecover = 2'd3
    } state_e;

    localparam int unsigned STROBE_CYC_DEFAULT = 2;

    localparam logic WR_IDLE = 1'b0;
    localparam logic RD_IDLE = 1'b1;
    localparam logic CS_IDLE = 1'b0;

endpackage

// File: rtl/rr_arb2.sv
// Two-way winner select. Round-robin on ties by default; with SRAM_ARB_FIXED_PRIO_EN
// defined, port 0 always wins ties and no last-grant pointer exists.
module rr_arb2 (
    input  logic clk,
    input  logic rst_n,
    input  logic req0,
    input  logic req1,
    input  logic take,
    output logic win
);

`ifdef SRAM_ARB_FIXED_PRIO_EN
    logic unused;
    assign unused = clk ^ rst_n ^ take;
    assign win    = ~req0 & req1;
`else
    logic last;

    // Tie goes to whichever port was not granted most recently.
    always_comb begin
        if (req0 && req1) win = ~last;
        else              win = req1;
    end

    // Reset to "port 1 last" so port 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (!rst_n)    last <= 1'b1;
        else if (take) last <= win;
    end
`endif

endmodule

// File: rtl/sram_arbiter.sv
// Two-port SRAM access arbiter with SETUP/STROBE/RECOVER timing and registered outputs.
// Tie policy selected by SRAM_ARB_FIXED_PRIO_EN (see rr_arb2).
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned STROBE_CYC = STROBE_CYC_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic       req1,
    input  logic       we0,
    input  logic       we1,
    input  logic [7:0] addr0,
    input  logic [7:0] addr1,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       rvalid0,
    output logic       rvalid1,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       sram_cs,
    output logic       sram_wr,
    output logic       sram_rd,
    output logic [7:0] sram_addr,
    output logic [7:0] sram_din,
    input  logic [7:0] sram_dout
);

    localparam logic [3:0] CntLast = 4'(STROBE_CYC - 1);

    state_e     state;
    logic [3:0] cnt;
    logic       we_q;
    logic       owner;
    logic       any_req;
    logic       win;
    logic       take;

    assign any_req = req0 | req1;
    assign take    = (state == StIdle) && any_req;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req0  (req0),
        .req1  (req1),
        .take  (take),
        .win   (win)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= StIdle;
            cnt       <= '0;
            we_q      <= 1'b0;
            owner     <= 1'b0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            rvalid0   <= 1'b0;
            rvalid1   <= 1'b0;
            rdata     <= '0;
            busy      <= 1'b0;
            sram_cs   <= CS_IDLE;
            sram_wr   <= WR_IDLE;
            sram_rd   <= RD_IDLE;
            sram_addr <= '0;
            sram_din  <= '0;
        end else begin
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (any_req) begin
                        state     <= StSetup;
                        owner     <= win;
                        we_q      <= win ? we1 : we0;
                        sram_addr <= win ? addr1 : addr0;
                        sram_din  <= win ? wdata1 : wdata0;
                        gnt0      <= ~win;
                        gnt1      <= win;
                        busy      <= 1'b1;
                        sram_cs   <= 1'b1;
                    end
                end
                StSetup: begin
                    state <= StStrobe;
                    cnt   <= '0;
                    if (we_q) sram_wr <= 1'b1;
                    else      sram_rd <= 1'b0;
                end
                StStrobe: begin
                    if (cnt == CntLast) begin
                        state   <= StRecover;
                        sram_wr <= WR_IDLE;
                        sram_rd <= RD_IDLE;
                        if (!we_q) begin
                            rdata   <= sram_dout;
                            rvalid0 <= ~owner;
                            rvalid1 <= owner;
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                StRecover: begin
                    state   <= StIdle;
                    busy    <= 1'b0;
                    sram_cs <= CS_IDLE;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a grant/read scoreboard and a behavioural SRAM.
module tb_sram_arbiter;

    localparam int unsigned SC = 2;

    typedef struct packed {
        logic       port;
        logic [7:0] data;
    } rd_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0, req1, we0, we1;
    logic [7:0] addr0, addr1, wdata0, wdata1;
    logic       gnt0, gnt1, rvalid0, rvalid1, busy;
    logic [7:0] rdata;
    logic       sram_cs, sram_wr, sram_rd;
    logic [7:0] sram_addr, sram_din, sram_dout;
    logic       preload;
    logic [7:0] mem [256];

    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  gnt_cyc = 0;
    int  rv_cyc = 0;
    bit  exp_gnt [$];
    rd_t exp_rd [$];

    always #5 clk = ~clk;

    sram_arbiter #(.STROBE_CYC(SC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (req0),
        .req1      (req1),
        .we0       (we0),
        .we1       (we1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .rvalid0   (rvalid0),
        .rvalid1   (rvalid1),
        .rdata     (rdata),
        .busy      (busy),
        .sram_cs   (sram_cs),
        .sram_wr   (sram_wr),
        .sram_rd   (sram_rd),
        .sram_addr (sram_addr),
        .sram_din  (sram_din),
        .sram_dout (sram_dout)
    );

    // Asynchronous-read SRAM, written while selected with the write strobe high.
    assign sram_dout = mem[sram_addr];
    always @(posedge clk) begin
        if (preload) begin
            mem[4] <= 8'h3C;
            mem[9] <= 8'h77;
        end else if (sram_cs && sram_wr) begin
            mem[sram_addr] <= sram_din;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic mon();
        bit  p;
        rd_t e;
        cyc++;
        if (!busy) begin
            chk("idle_cs", 32'(sram_cs), 32'd0);
            chk("idle_wr", 32'(sram_wr), 32'd0);
            chk("idle_rd", 32'(sram_rd), 32'd1);
        end
        if (gnt0 || gnt1) begin
            gnt_cyc = cyc;
            chk("gnt_expected", 32'(exp_gnt.size() > 0), 32'd1);
            if (exp_gnt.size() > 0) begin
                p = exp_gnt.pop_front();
                chk("gnt_port", 32'({gnt1, gnt0}), p ? 32'd2 : 32'd1);
            end
        end
        if (rvalid0 || rvalid1) begin
            rv_cyc = cyc;
            chk("rvalid_expected", 32'(exp_rd.size() > 0), 32'd1);
            if (exp_rd.size() > 0) begin
                e = exp_rd.pop_front();
                chk("rvalid_port", 32'({rvalid1, rvalid0}), e.port ? 32'd2 : 32'd1);
                chk("rdata", 32'(rdata), 32'(e.data));
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        mon();
    endtask

    // Run until the FSM returns to IDLE, checking the latched address/data and counting strobes.
    task automatic wait_done(input logic [7:0] ea, input logic [7:0] ed, input bit chk_din,
                             output int wr_n, output int rd_n);
        int n = 0;
        wr_n = 0;
        rd_n = 0;
        do begin
            tick();
            n++;
            if (sram_wr === 1'b1) wr_n++;
            if (sram_rd === 1'b0) rd_n++;
            if (sram_cs === 1'b1) begin
                chk("txn_addr", 32'(sram_addr), 32'(ea));
                if (chk_din) chk("txn_din", 32'(sram_din), 32'(ed));
            end
        end while (busy !== 1'b0 && n < 20);
        chk("txn_bound", 32'(n < 20), 32'd1);
    endtask

    task automatic both_round();
        int n = 0;
        exp_gnt.push_back(1'b0);
        exp_gnt.push_back(1'b1);
        exp_rd.push_back({1'b0, 8'h3C});
        exp_rd.push_back({1'b1, 8'hA2});
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h04;
        req1 = 1'b1; we1 = 1'b0; addr1 = 8'h05;
        while ((req0 || req1 || busy !== 1'b0) && n < 40) begin
            tick();
            n++;
            if (gnt0) req0 = 1'b0;
            if (gnt1) req1 = 1'b0;
        end
        chk("round_bound", 32'(n < 40), 32'd1);
        chk("round_gnt_drained", 32'(exp_gnt.size()), 32'd0);
        chk("round_rd_drained", 32'(exp_rd.size()), 32'd0);
    endtask

    initial begin
        int wr_n, rd_n, g1, g2, n;
        rst_n = 1'b0; preload = 1'b1;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        tick();
        tick();
        chk("rst_cs", 32'(sram_cs), 32'd0);
        chk("rst_wr", 32'(sram_wr), 32'd0);
        chk("rst_rd", 32'(sram_rd), 32'd1);
        chk("rst_addr", 32'(sram_addr), 32'd0);
        chk("rst_din", 32'(sram_din), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pulses", 32'({gnt0, gnt1, rvalid0, rvalid1}), 32'd0);
        rst_n = 1'b1; preload = 1'b0;
        tick();

        // Port 0 write 0xA2 to 0x05.
        exp_gnt.push_back(1'b0);
        req0 = 1'b1; we0 = 1'b1; addr0 = 8'h05; wdata0 = 8'hA2;
        tick();
        chk("a_gnt0", 32'(gnt0), 32'd1);
        chk("a_busy", 32'(busy), 32'd1);
        chk("a_addr_setup", 32'(sram_addr), 32'h05);
        req0 = 1'b0;
        wait_done(8'h05, 8'hA2, 1'b1, wr_n, rd_n);
        chk("a_wr_cycles", 32'(wr_n), 32'(SC));
        chk("a_rd_cycles", 32'(rd_n), 32'd0);
        chk("a_rdata_untouched", 32'(rdata), 32'd0);

        // Port 1 read back from 0x05.
        exp_gnt.push_back(1'b1);
        exp_rd.push_back({1'b1, 8'hA2});
        req1 = 1'b1; we1 = 1'b0; addr1 = 8'h05;
        tick();
        chk("b_gnt1", 32'(gnt1), 32'd1);
        req1 = 1'b0;
        wait_done(8'h05, 8'h00, 1'b0, wr_n, rd_n);
        chk("b_rd_cycles", 32'(rd_n), 32'(SC));
        chk("b_wr_cycles", 32'(wr_n), 32'd0);
        chk("b_latency", 32'(rv_cyc - gnt_cyc), 32'(SC + 1));
        chk("b_rdata_hold", 32'(rdata), 32'hA2);
        chk("b_rd_drained", 32'(exp_rd.size()), 32'd0);

        // Simultaneous reads, twice: grants alternate 0,1,0,1.
        both_round();
        both_round();

        // Held req0: back-to-back grants spaced by one full transaction.
        exp_gnt.push_back(1'b0);
        exp_gnt.push_back(1'b0);
        req0 = 1'b1; we0 = 1'b1; addr0 = 8'h06; wdata0 = 8'h11;
        g1 = -1; g2 = -1; n = 0;
        while (g2 < 0 && n < 30) begin
            tick();
            n++;
            if (gnt0) begin
                if (g1 < 0) g1 = cyc;
                else        g2 = cyc;
            end
        end
        req0 = 1'b0;
        chk("d_second_gnt", 32'(g2 >= 0), 32'd1);
        chk("d_spacing", 32'(g2 - g1), 32'(SC + 3));
        wait_done(8'h06, 8'h11, 1'b1, wr_n, rd_n);

        // req1 rises mid-write of port 0; it must wait for IDLE.
        exp_gnt.push_back(1'b0);
        req0 = 1'b1; we0 = 1'b1; addr0 = 8'h07; wdata0 = 8'h5A;
        tick();
        req0 = 1'b0;
        tick();
        exp_gnt.push_back(1'b1);
        exp_rd.push_back({1'b1, 8'h77});
        req1 = 1'b1; we1 = 1'b0; addr1 = 8'h09;
        addr0 = 8'hEE;
        n = 0;
        while (busy !== 1'b0 && n < 20) begin
            chk("e_addr_stable", 32'(sram_addr), 32'h07);
            chk("e_din_stable", 32'(sram_din), 32'h5A);
            chk("e_no_gnt1", 32'(gnt1), 32'd0);
            tick();
            n++;
        end
        chk("e_bound", 32'(n < 20), 32'd1);
        tick();
        chk("e_gnt1_after_idle", 32'(gnt1), 32'd1);
        req1 = 1'b0;
        wait_done(8'h09, 8'h00, 1'b0, wr_n, rd_n);
        chk("e_rdata", 32'(rdata), 32'h77);

        // Reset during STROBE aborts a port 0 read.
        exp_gnt.push_back(1'b0);
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h04;
        tick();
        req0 = 1'b0;
        tick();
        chk("f_in_strobe", 32'(sram_rd), 32'd0);
        rst_n = 1'b0;
        tick();
        tick();
        chk("f_cs", 32'(sram_cs), 32'd0);
        chk("f_wr", 32'(sram_wr), 32'd0);
        chk("f_rd", 32'(sram_rd), 32'd1);
        chk("f_busy", 32'(busy), 32'd0);
        chk("f_rvalid", 32'({rvalid0, rvalid1}), 32'd0);
        chk("f_rdata", 32'(rdata), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("f_busy_after", 32'(busy), 32'd0);
        // Pointer is back to its reset value: port 0 wins the tie again.
        both_round();

        chk("end_gnt_drained", 32'(exp_gnt.size()), 32'd0);
        chk("end_rd_drained", 32'(exp_rd.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
